// File: rtl/countdown_pkg.sv
// Shared types, segment constants and BCD helper for the countdown display controller.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Index 0 is the rightmost element: "0" = C0 ... "9" = 90, active-low, dp off.
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern; invalid codes show a dash.
module bcd_to_7seg
    import countdown_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/countdown_display_ctrl.sv
// Two-digit BCD countdown with debounced start key and direct 7-segment drive.
// Optional BLINK_DONE_EN: digits blink between "00" and blank while in DONE.
module countdown_display_ctrl
    import countdown_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       start_btn_n,
    input  logic [3:0] chave,
    output logic [7:0] unidade,
    output logic [7:0] dezena,
    output logic       running,
    output logic       done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_prev_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          start_pulse;

    state_t        state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    preset;
    logic [7:0]    count_dec;

    logic [7:0]    seg_u, seg_t;
    logic [7:0]    unidade_q, unidade_d;
    logic [7:0]    dezena_q, dezena_d;
    logic          running_q, done_q;

    // Stable level only follows the synchronised key after a full unbroken run.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_MAX) begin
                stable_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
    end

    assign start_pulse = stable_prev_q & ~stable_q;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            db_cnt_q      <= '0;
        end else begin
            sync1_q       <= start_btn_n;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q      <= db_cnt_d;
        end
    end

    always_comb begin
        preset = 8'h99;
        if (chave <= 4'd9) begin
            preset = {chave, 4'd0};
        end
    end

    assign count_dec = bcd_dec(count_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        unique case (state_q)
            IDLE: begin
                count_d = preset;
                if (start_pulse) begin
                    presc_d = '0;
                    state_d = (preset == 8'h00) ? DONE : RUN;
                end
            end
            RUN: begin
                if (start_pulse) begin
                    state_d = PAUSE;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    count_d = count_dec;
                    if (count_dec == 8'h00) begin
                        state_d = DONE;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            PAUSE: begin
                if (start_pulse) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                count_d = 8'h00;
                if (start_pulse) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            count_q <= 8'h00;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

    bcd_to_7seg u_seg_units (
        .bcd (count_q[3:0]),
        .seg (seg_u)
    );

    bcd_to_7seg u_seg_tens (
        .bcd (count_q[7:4]),
        .seg (seg_t)
    );

`ifdef BLINK_DONE_EN
    logic          blink_q, blink_d;
    logic [PW-1:0] blink_cnt_q, blink_cnt_d;

    // Cleared on entry so DONE always opens with a visible "00".
    always_comb begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (state_d == DONE && state_q != DONE) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (state_q == DONE) begin
            if (blink_cnt_q == PRESC_MAX) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    always_comb begin
        unidade_d = seg_u;
        dezena_d  = seg_t;
        if (state_q == DONE && blink_q) begin
            unidade_d = SEG_BLANK;
            dezena_d  = SEG_BLANK;
        end
    end
`else
    always_comb begin
        unidade_d = seg_u;
        dezena_d  = seg_t;
    end
`endif

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            unidade_q <= SEG_TABLE[0];
            dezena_q  <= SEG_TABLE[0];
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unidade_q <= unidade_d;
            dezena_q  <= dezena_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    assign unidade = unidade_q;
    assign dezena  = dezena_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_display_ctrl.sv
// Randomised bench for countdown_display_ctrl against an integer-count reference model.
module tb_countdown_display_ctrl;

    localparam int TICK = 4;
    localparam int DEB  = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_n = 1'b1;
    logic [3:0] chave = 4'd3;
    logic [7:0] unidade, dezena;
    logic       running, done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] segtab [10];

    // Reference model state: count kept as a plain integer 0..99.
    int   m_n, m_presc, m_st, m_st0, m_run, m_bcnt;
    logic m_s1, m_s2, m_stable, m_prev, m_blink, m_pulse;
    logic [7:0] m_uni, m_dez, nu, nd;
    logic m_running, m_done;

    countdown_display_ctrl #(
        .TICK_DIV        (TICK),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .start_btn_n   (btn_n),
        .chave         (chave),
        .unidade       (unidade),
        .dezena        (dezena),
        .running       (running),
        .done          (done)
    );

    always #5 clk = ~clk;

    function automatic int preset_of(input logic [3:0] c);
        return (c <= 4'd9) ? int'(c) * 10 : 99;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_stable = 1'b1; m_prev = 1'b1;
            m_run = 0; m_st = M_IDLE; m_n = 0; m_presc = 0;
            m_blink = 1'b0; m_bcnt = 0;
            m_uni = segtab[0]; m_dez = segtab[0];
            m_running = 1'b0; m_done = 1'b0;
        end else begin
            m_pulse = m_prev && !m_stable;
            m_st0 = m_st;
            nu = segtab[m_n % 10];
            nd = segtab[m_n / 10];
`ifdef BLINK_DONE_EN
            if (m_st0 == M_DONE && m_blink) begin
                nu = 8'hFF;
                nd = 8'hFF;
            end
`endif
            m_prev = m_stable;
            if (m_s2 != m_stable) begin
                if (m_run == DEB - 1) begin
                    m_stable = m_s2;
                    m_run = 0;
                end else begin
                    m_run++;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn_n;
            case (m_st0)
                M_IDLE: begin
                    m_n = preset_of(chave);
                    if (m_pulse) begin
                        m_presc = 0;
                        m_st = (m_n == 0) ? M_DONE : M_RUN;
                    end
                end
                M_RUN: begin
                    if (m_pulse) begin
                        m_st = M_PAUSE;
                    end else if (m_presc == TICK - 1) begin
                        m_presc = 0;
                        m_n = m_n - 1;
                        if (m_n == 0) m_st = M_DONE;
                    end else begin
                        m_presc++;
                    end
                end
                M_PAUSE: if (m_pulse) m_st = M_RUN;
                default: begin
                    m_n = 0;
                    if (m_pulse) m_st = M_IDLE;
                end
            endcase
            if (m_st == M_DONE && m_st0 != M_DONE) begin
                m_blink = 1'b0;
                m_bcnt = 0;
            end else if (m_st0 == M_DONE) begin
                if (m_bcnt == TICK - 1) begin
                    m_bcnt = 0;
                    m_blink = !m_blink;
                end else begin
                    m_bcnt++;
                end
            end
            m_uni = nu;
            m_dez = nd;
            m_running = (m_st == M_RUN);
            m_done = (m_st == M_DONE);
        end
    end

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("unidade", unidade, m_uni);
            check("dezena", dezena, m_dez);
            check("running", {7'd0, running}, {7'd0, m_running});
            check("done", {7'd0, done}, {7'd0, m_done});
        end
    endtask

    task automatic press(input int hold, input int rel);
        btn_n = 1'b0;
        step(hold);
        btn_n = 1'b1;
        step(rel);
    endtask

    initial begin
        int op;
        segtab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        rst_n = 1'b0;
        chave = 4'd3;
        step(3);
        rst_n = 1'b1;
        step(3);
        chave = 4'd1;
        press(2, 10);
        press(6, 60);
        chave = 4'd2;
        press(6, 6);
        press(6, 20);
        press(6, 80);
        chave = 4'd12;
        step(4);
        chave = 4'd0;
        press(6, 20);
        for (int k = 0; k < 160; k++) begin
            op = $urandom_range(0, 9);
            if (op <= 1) begin
                chave = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 3));
                step(2);
            end else if (op <= 6) begin
                press($urandom_range(1, 8), $urandom_range(1, 12));
            end else if (op <= 8) begin
                step($urandom_range(1, 60));
            end else begin
                rst_n = 1'b0;
                step($urandom_range(1, 3));
                rst_n = 1'b1;
                step(2);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
